// File: rtl/multi_timer.sv
// N-channel MMIO timer/counter with one-shot and auto-reload modes, W1C pending flags and IRQs.
// Optional: define TIMER_PRESCALE_EN for a per-channel 8-bit prescaler in CTRL[15:8].
module multi_timer #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned CH_BITS = 3
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [N_CH-1:0] IRQ_vec,
  output logic            IRQ
);
  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e           r_st     [N_CH];
  logic             r_en     [N_CH];
  logic [1:0]       r_mode   [N_CH];
  logic             r_im     [N_CH];
  logic             r_pend   [N_CH];
  logic [CNT_W-1:0] r_preset [N_CH];
  logic [CNT_W-1:0] r_count  [N_CH];
`ifdef TIMER_PRESCALE_EN
  logic [7:0]       r_psc    [N_CH];
  logic [7:0]       r_pcnt   [N_CH];
`endif

  logic [1:0]         w_off;
  logic [CH_BITS-1:0] w_ch;
  logic               w_ch_ok;
  logic [N_CH-1:0]    w_wr;
  logic [N_CH-1:0]    w_tick;
  logic               w_unused;

  assign w_off    = Addr[3:2];
  assign w_ch     = Addr[4+CH_BITS-1:4];
  assign w_ch_ok  = 32'(w_ch) < N_CH;
  assign w_unused = ^{Addr[31:4+CH_BITS], Din};

  always_comb begin
    w_wr   = '0;
    w_tick = '1;
    for (int i = 0; i < N_CH; i++) begin
      w_wr[i] = WE && w_ch_ok && (w_ch == CH_BITS'(i));
`ifdef TIMER_PRESCALE_EN
      w_tick[i] = (r_pcnt[i] == r_psc[i]);
`endif
    end
  end

  // A bus write to a channel freezes that channel's FSM for the cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_st[i]     <= StIdle;
        r_en[i]     <= 1'b0;
        r_mode[i]   <= 2'b00;
        r_im[i]     <= 1'b0;
        r_pend[i]   <= 1'b0;
        r_preset[i] <= '0;
        r_count[i]  <= '0;
`ifdef TIMER_PRESCALE_EN
        r_psc[i]    <= 8'd0;
        r_pcnt[i]   <= 8'd0;
`endif
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr[i]) begin
          case (w_off)
            2'd0: begin
              r_en[i]   <= Din[0];
              r_mode[i] <= Din[2:1];
              r_im[i]   <= Din[3];
`ifdef TIMER_PRESCALE_EN
              r_psc[i]  <= Din[15:8];
`endif
            end
            2'd1: r_preset[i] <= Din[CNT_W-1:0];
            2'd2: r_count[i]  <= Din[CNT_W-1:0];
            default: if (Din[0]) r_pend[i] <= 1'b0;
          endcase
        end else begin
          case (r_st[i])
            StIdle: if (r_en[i]) r_st[i] <= StLoad;
            StLoad: begin
              r_count[i] <= r_preset[i];
              r_st[i]    <= StCnt;
`ifdef TIMER_PRESCALE_EN
              r_pcnt[i]  <= 8'd0;
`endif
            end
            StCnt: begin
              if (!r_en[i]) begin
                r_st[i] <= StIdle;
              end else if (w_tick[i]) begin
                // PRESET of 0 expires like PRESET of 1.
                if (r_count[i] > CNT_W'(1)) begin
                  r_count[i] <= r_count[i] - CNT_W'(1);
                end else begin
                  r_count[i] <= '0;
                  r_pend[i]  <= 1'b1;
                  r_st[i]    <= StInt;
                end
              end
`ifdef TIMER_PRESCALE_EN
              if (r_en[i]) r_pcnt[i] <= w_tick[i] ? 8'd0 : r_pcnt[i] + 8'd1;
`endif
            end
            StInt: begin
              if (r_mode[i] == 2'b01) begin
                r_st[i] <= r_en[i] ? StLoad : StIdle;
              end else begin
                r_en[i] <= 1'b0;
                r_st[i] <= StIdle;
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    Dout    = 32'd0;
    IRQ_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      IRQ_vec[i] = r_pend[i] & r_im[i];
      if (w_ch_ok && (w_ch == CH_BITS'(i))) begin
        case (w_off)
          2'd0: begin
            Dout = {28'd0, r_im[i], r_mode[i], r_en[i]};
`ifdef TIMER_PRESCALE_EN
            Dout[15:8] = r_psc[i];
`endif
          end
          2'd1:    Dout = 32'(r_preset[i]);
          2'd2:    Dout = 32'(r_count[i]);
          default: Dout = {31'd0, r_pend[i]};
        endcase
      end
    end
  end

  assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: register table, then timed sequences per channel.
`timescale 1ns/1ps
module tb_multi_timer;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned CH_BITS = 3;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PscMask = 32'h0000_FF00;
`else
  localparam logic [31:0] PscMask = 32'h0000_0000;
`endif

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            WE = 1'b0;
  logic [29:0]     Addr = '0;
  logic [31:0]     Din = '0;
  logic [31:0]     Dout;
  logic [N_CH-1:0] IRQ_vec;
  logic            IRQ;

  multi_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_BITS(CH_BITS)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ_vec(IRQ_vec), .IRQ(IRQ)
  );

  always #50 Clk = ~Clk;

  typedef struct { string name; logic [31:0] exp; } exp_t;
  typedef struct { bit we; int ch; int off; logic [31:0] d; string name; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [29:0] mk(int ch, int off);
    logic [29:0] a;
    a = '0;
    a[1:0] = off[1:0];
    a[2 +: CH_BITS] = ch[CH_BITS-1:0];
    return a;
  endfunction

  function automatic void check_pop(logic [31:0] act);
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endfunction

  task automatic expect_reg(string name, int ch, int off, logic [31:0] exp);
    WE   = 1'b0;
    Addr = mk(ch, off);
    sb.push_back('{name: name, exp: exp});
    #1;
    check_pop(Dout);
  endtask

  task automatic expect_irq(string name, logic [N_CH-1:0] vec);
    sb.push_back('{name: name, exp: {29'd0, |vec, vec}});
    #1;
    check_pop({29'd0, IRQ, IRQ_vec});
  endtask

  task automatic wr(int ch, int off, logic [31:0] d);
    Addr = mk(ch, off);
    Din  = d;
    WE   = 1'b1;
    @(negedge Clk);
    WE   = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    WE    = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic vec_t rv(int ch, int off, logic [31:0] exp, string name);
    return '{we: 1'b0, ch: ch, off: off, d: exp, name: name};
  endfunction

  function automatic vec_t wv(int ch, int off, logic [31:0] d);
    return '{we: 1'b1, ch: ch, off: off, d: d, name: ""};
  endfunction

  initial begin
    // Register-access table, starting from reset.
    for (int c = 0; c < 2; c++)
      for (int o = 0; o < 4; o++) tbl.push_back(rv(c, o, 32'h0, $sformatf("rst_ch%0d_off%0d", c, o)));
    tbl.push_back(rv(5, 0, 32'h0, "ch5_ctrl"));
    tbl.push_back(wv(5, 1, 32'h0000_00AB));
    tbl.push_back(rv(5, 1, 32'h0, "ch5_preset"));
    tbl.push_back(rv(1, 1, 32'h0, "ch1_preset_alias"));
    tbl.push_back(wv(1, 1, 32'hFFFF_FFFF));
    tbl.push_back(rv(1, 1, 32'hFFFF_FFFF, "ch1_preset_full"));
    tbl.push_back(wv(1, 0, 32'hFFFF_FFF6));
    tbl.push_back(rv(1, 0, 32'h6 | (32'hFFFF_FFF6 & PscMask), "ch1_ctrl_bits"));
    tbl.push_back(wv(0, 0, 32'h0000_0301));
    tbl.push_back(rv(0, 0, 32'h1 | (32'h0000_0301 & PscMask), "ch0_ctrl_0301"));
    tbl.push_back(wv(0, 0, 32'h0));
    tbl.push_back(wv(0, 3, 32'h0));
    tbl.push_back(rv(0, 3, 32'h0, "ch0_stat_w0"));

    cyc(1);
    do_reset();
    expect_irq("rst_irq", 2'b00);
    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].ch, tbl[i].off, tbl[i].d);
      else expect_reg(tbl[i].name, tbl[i].ch, tbl[i].off, tbl[i].d);
    end

    // One-shot on ch0, PRESET=5.
    do_reset();
    wr(0, 1, 5);
    wr(0, 0, 32'h9);
    expect_reg("os_cnt_t0", 0, 2, 0);
    cyc(1); expect_reg("os_cnt_t1", 0, 2, 0);
    cyc(1); expect_reg("os_cnt_t2", 0, 2, 5);
    cyc(4); expect_reg("os_cnt_t6", 0, 2, 1);
    expect_reg("os_pend_t6", 0, 3, 0);
    cyc(1); expect_reg("os_pend_t7", 0, 3, 1);
    expect_irq("os_irq_t7", 2'b01);
    cyc(1); expect_reg("os_ctrl_t8", 0, 0, 32'h8);
    expect_reg("os_cnt_t8", 0, 2, 0);
    cyc(5); expect_reg("os_cnt_idle", 0, 2, 0);
    expect_reg("os_pend_sticky", 0, 3, 1);
    wr(0, 3, 1);
    expect_reg("os_w1c", 0, 3, 0);
    expect_irq("os_w1c_irq", 2'b00);

    // Auto-reload on ch1, PRESET=3.
    wr(1, 1, 3);
    wr(1, 0, 32'hB);
    cyc(4); expect_reg("ar_pend_t4", 1, 3, 0);
    cyc(1); expect_reg("ar_pend_t5", 1, 3, 1);
    expect_irq("ar_irq_t5", 2'b10);
    wr(1, 3, 1);
    expect_irq("ar_w1c_irq", 2'b00);
    cyc(4); expect_reg("ar_pend_t10", 1, 3, 0);
    cyc(1); expect_reg("ar_pend_t11", 1, 3, 1);
    expect_irq("ar_irq_t11", 2'b10);
    wr(1, 3, 0);
    expect_reg("ar_w0_nochg", 1, 3, 1);
    cyc(2); expect_reg("ar_cnt_t14", 1, 2, 3);
    cyc(3); expect_reg("ar_cnt_t17", 1, 2, 0);
    cyc(2); expect_reg("ar_cnt_t19", 1, 2, 3);
    cyc(2); expect_reg("ar_cnt_t21", 1, 2, 1);
    cyc(1); expect_reg("ar_cnt_t22", 1, 2, 0);

    // Write stall: ch0 frozen by PRESET writes, ch1 keeps its timing.
    do_reset();
    wr(0, 1, 10);
    wr(0, 0, 32'h9);
    wr(1, 1, 3);
    wr(1, 0, 32'hB);
    for (int k = 1; k <= 8; k++) begin
      Addr = mk(0, 1);
      Din  = 32'(20 + k);
      WE   = 1'b1;
      @(negedge Clk);
      if (k == 4) expect_irq("stall_irq_s4", 2'b00);
      if (k == 5) expect_irq("stall_irq_s5", 2'b10);
    end
    WE = 1'b0;
    expect_reg("stall_ch0_cnt", 0, 2, 10);
    expect_reg("stall_ch0_preset", 0, 1, 28);
    expect_reg("stall_ch1_cnt", 1, 2, 2);

    // Reset mid-count.
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    expect_reg("mrst_ch0_cnt", 0, 2, 0);
    expect_reg("mrst_ch0_ctrl", 0, 0, 0);
    expect_reg("mrst_ch0_preset", 0, 1, 0);
    expect_reg("mrst_ch1_ctrl", 1, 0, 0);
    expect_reg("mrst_ch1_pend", 1, 3, 0);
    expect_irq("mrst_irq", 2'b00);
    cyc(3);
    expect_reg("mrst_ch0_cnt_later", 0, 2, 0);
    expect_reg("mrst_ch1_cnt_later", 1, 2, 0);

    // Masked expiry, then unmask/mask without losing PEND.
    wr(0, 1, 2);
    wr(0, 0, 32'h1);
    cyc(3); expect_reg("im_pend_t3", 0, 3, 0);
    cyc(1); expect_reg("im_pend_t4", 0, 3, 1);
    expect_irq("im_masked", 2'b00);
    wr(0, 0, 32'h8);
    expect_irq("im_unmask", 2'b01);
    wr(0, 0, 32'h0);
    expect_irq("im_remask", 2'b00);
    expect_reg("im_pend_kept", 0, 3, 1);
    wr(0, 0, 32'h8);
    expect_irq("im_unmask2", 2'b01);
    wr(0, 3, 1);
    expect_irq("im_w1c", 2'b00);

    // COUNT write while counting on ch1.
    wr(1, 1, 20);
    wr(1, 0, 32'h1);
    cyc(3); expect_reg("cw_cnt_t3", 1, 2, 19);
    wr(1, 2, 2);
    expect_reg("cw_cnt_written", 1, 2, 2);
    cyc(1); expect_reg("cw_cnt_next", 1, 2, 1);
    expect_reg("cw_pend_next", 1, 3, 0);
    cyc(1); expect_reg("cw_pend_exp", 1, 3, 1);

    // MODE=11 behaves as one-shot; PRESET=0 behaves as PRESET=1.
    do_reset();
    wr(0, 1, 0);
    wr(0, 0, 32'h7);
    cyc(2); expect_reg("p0_pend_t2", 0, 3, 0);
    cyc(1); expect_reg("p0_pend_t3", 0, 3, 1);
    cyc(1); expect_reg("m3_ctrl_t4", 0, 0, 32'h6);
    cyc(3); expect_reg("m3_ctrl_t7", 0, 0, 32'h6);
    expect_reg("m3_cnt_t7", 0, 2, 0);

`ifdef TIMER_PRESCALE_EN
    // PSC=3, PRESET=2: expiry after 8 clocks in counting.
    do_reset();
    wr(0, 1, 2);
    wr(0, 0, 32'h0309);
    cyc(5); expect_reg("psc_cnt_t5", 0, 2, 2);
    cyc(1); expect_reg("psc_cnt_t6", 0, 2, 1);
    cyc(3); expect_reg("psc_pend_t9", 0, 3, 0);
    cyc(1); expect_reg("psc_pend_t10", 0, 3, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
